// File: rtl/uart_mem_bridge_if.sv
// Serial-byte and host-bus signal bundle between uart_mem_bridge and its surroundings.
// The master modport is the bridge's view; slave is the UART pair plus bus side.
interface uart_mem_bridge_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_data_valid;
  logic        o_rx_data_rdy;
  logic [7:0]  o_tx_data;
  logic        o_tx_data_valid;
  logic        i_tx_data_rdy;
  logic [1:0]  o_mem_op;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_data;
  logic [63:0] i_mem_data;
  logic        i_mem_op_pending;

  modport master (
    input  i_rx_data, i_rx_data_valid, i_tx_data_rdy, i_mem_data, i_mem_op_pending,
    output o_rx_data_rdy, o_tx_data, o_tx_data_valid, o_mem_op, o_mem_addr, o_mem_data
  );

  modport slave (
    output i_rx_data, i_rx_data_valid, i_tx_data_rdy, i_mem_data, i_mem_op_pending,
    input  o_rx_data_rdy, o_tx_data, o_tx_data_valid, o_mem_op, o_mem_addr, o_mem_data
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// Serial-to-host-bus bridge: deframes READ/WRITE commands from uart_rx, issues one bus
// operation, and frames the response (read data, 0xAA ack or 0xEE error) back to uart_tx.
module uart_mem_bridge #(
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int PEND_WAIT_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  uart_mem_bridge_if.master    bus,
  output logic                 o_busy,
  output logic [7:0]           o_err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ISSUE, S_PEND, S_DONE, S_TX
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(PEND_WAIT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PEND_LAST = PW'(PEND_WAIT_CYCLES - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t         state_q, state_d;
  logic           is_wr_q, is_wr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [PW-1:0]  pend_q, pend_d;
  logic [63:0]    addr_q, addr_d;
  logic [63:0]    data_q, data_d;
  logic [63:0]    tx_sh_q, tx_sh_d;
  logic [3:0]     tx_left_q, tx_left_d;
  logic           tx_vld_q, tx_vld_d;
  logic           tx_gap_q, tx_gap_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic [1:0]     op_q, op_d;
  logic [63:0]    maddr_q, maddr_d;
  logic [63:0]    mdata_q, mdata_d;
  logic [7:0]     err_q, err_d;

  logic rx_rdy;
  logic accept;

  assign rx_rdy = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign accept = rx_rdy && bus.i_rx_data_valid;

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    pend_d    = pend_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tx_sh_d   = tx_sh_q;
    tx_left_d = tx_left_q;
    tx_vld_d  = 1'b0;
    tx_gap_d  = tx_vld_q;
    tx_byte_d = tx_byte_q;
    op_d      = OP_NOP;
    maddr_d   = maddr_q;
    mdata_d   = mdata_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.i_rx_data == 8'h01 || bus.i_rx_data == 8'h02) begin
            is_wr_d = (bus.i_rx_data == 8'h02);
            cnt_d   = 3'd0;
            tmo_d   = '0;
            state_d = S_ADDR;
          end else begin
            tx_sh_d   = 64'h0000_0000_0000_00EE;
            tx_left_d = 4'd1;
            err_d     = sat_inc8(err_q);
            state_d   = S_TX;
          end
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_d = {bus.i_rx_data, addr_q[63:8]};
          tmo_d  = '0;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = is_wr_q ? S_DATA : S_ISSUE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = sat_inc8(err_q);
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DATA: begin
        if (accept) begin
          data_d = {bus.i_rx_data, data_q[63:8]};
          tmo_d  = '0;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = S_ISSUE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = sat_inc8(err_q);
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (is_wr_q) begin
          tx_sh_d   = 64'h0000_0000_0000_00AA;
          tx_left_d = 4'd1;
          state_d   = S_TX;
        end else begin
          pend_d  = '0;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        // Register-space reads never raise pending; fall back to sampling data directly.
        if (bus.i_mem_op_pending) begin
          state_d = S_DONE;
        end else if (pend_q == PEND_LAST) begin
          tx_sh_d   = bus.i_mem_data;
          tx_left_d = 4'd8;
          state_d   = S_TX;
        end else begin
          pend_d = pend_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!bus.i_mem_op_pending) begin
          tx_sh_d   = bus.i_mem_data;
          tx_left_d = 4'd8;
          state_d   = S_TX;
        end
      end
      S_TX: begin
        // Two quiet cycles after each pulse cover uart_tx's lagging rdy deassert.
        if (tx_left_q == 4'd0) begin
          state_d = S_IDLE;
        end else if (bus.i_tx_data_rdy && !tx_vld_q && !tx_gap_q) begin
          tx_vld_d  = 1'b1;
          tx_byte_d = tx_sh_q[7:0];
          tx_sh_d   = {8'h00, tx_sh_q[63:8]};
          tx_left_d = tx_left_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered so op is high exactly during the S_ISSUE cycle.
    if (state_d == S_ISSUE) begin
      op_d    = is_wr_q ? OP_WRITE : OP_READ;
      maddr_d = addr_d;
      mdata_d = data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      cnt_q     <= 3'd0;
      tmo_q     <= '0;
      pend_q    <= '0;
      addr_q    <= 64'd0;
      data_q    <= 64'd0;
      tx_sh_q   <= 64'd0;
      tx_left_q <= 4'd0;
      tx_vld_q  <= 1'b0;
      tx_gap_q  <= 1'b0;
      tx_byte_q <= 8'd0;
      op_q      <= OP_NOP;
      maddr_q   <= 64'd0;
      mdata_q   <= 64'd0;
      err_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tx_sh_q   <= tx_sh_d;
      tx_left_q <= tx_left_d;
      tx_vld_q  <= tx_vld_d;
      tx_gap_q  <= tx_gap_d;
      tx_byte_q <= tx_byte_d;
      op_q      <= op_d;
      maddr_q   <= maddr_d;
      mdata_q   <= mdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_rx_data_rdy   = rx_rdy;
  assign bus.o_tx_data       = tx_byte_q;
  assign bus.o_tx_data_valid = tx_vld_q;
  assign bus.o_mem_op        = op_q;
  assign bus.o_mem_addr      = maddr_q;
  assign bus.o_mem_data      = mdata_q;
  assign o_busy              = (state_q != S_IDLE);
  assign o_err_count         = err_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Scoreboard bench for uart_mem_bridge: directed frames push expected bus ops and tx bytes,
// independent monitors pop and compare whenever the bridge presents them.
module tb_uart_mem_bridge;
  localparam int TMO = 1024;
  localparam int PW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_mem_bridge_if bus();
  logic       busy;
  logic [7:0] err;

  uart_mem_bridge #(.TIMEOUT_CYCLES(TMO), .PEND_WAIT_CYCLES(PW)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .o_busy(busy), .o_err_count(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    bit          chk_data;
  } op_t;

  op_t        exp_op[$];
  logic [7:0] exp_tx[$];

  // uart_tx model: rdy drops the edge after a pulse and stays low for a while.
  int tx_cnt = 0;
  always @(posedge clk) begin
    if (bus.o_tx_data_valid === 1'b1) tx_cnt <= 10;
    else if (tx_cnt > 0)              tx_cnt <= tx_cnt - 1;
  end
  assign bus.i_tx_data_rdy = (tx_cnt == 0);

  // Bus model: memory reads pend for 2 cycles, register space (bit 63) reads return 1 with no pending.
  bit [63:0]   mem [0:255];
  int          pend_left = 0;
  logic [63:0] rdata = 64'd0;
  always @(posedge clk) begin
    if (pend_left > 0) pend_left <= pend_left - 1;
    if (bus.o_mem_op === 2'd2) begin
      mem[bus.o_mem_addr[7:0]] <= bus.o_mem_data;
    end else if (bus.o_mem_op === 2'd1) begin
      if (bus.o_mem_addr[63]) begin
        rdata <= 64'd1;
      end else begin
        rdata     <= mem[bus.o_mem_addr[7:0]];
        pend_left <= 2;
      end
    end
  end
  assign bus.i_mem_op_pending = (pend_left != 0);
  assign bus.i_mem_data       = rdata;

  logic prev_vld = 1'b0;
  always @(negedge clk) begin : mon_tx
    logic [7:0] e;
    if (bus.o_tx_data_valid === 1'b1) begin
      check("tx_no_back_to_back", 64'(prev_vld), 64'd0);
      if (exp_tx.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL tx_unexpected: got byte %h, required no byte", bus.o_tx_data);
      end else begin
        e = exp_tx.pop_front();
        check("tx_byte", 64'(bus.o_tx_data), 64'(e));
      end
    end
    prev_vld <= (bus.o_tx_data_valid === 1'b1);
  end

  always @(negedge clk) begin : mon_op
    op_t o;
    if (bus.o_mem_op === 2'd1 || bus.o_mem_op === 2'd2 || bus.o_mem_op === 2'd3) begin
      if (exp_op.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mem_op_unexpected: got op %0d addr %h, required NOP", bus.o_mem_op, bus.o_mem_addr);
      end else begin
        o = exp_op.pop_front();
        check("mem_op", 64'(bus.o_mem_op), 64'(o.op));
        check("mem_addr", bus.o_mem_addr, o.addr);
        if (o.chk_data) check("mem_data", bus.o_mem_data, o.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.i_rx_data       = b;
    bus.i_rx_data_valid = 1'b1;
    while (bus.o_rx_data_rdy !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_now("rx_rdy_wait");
    @(negedge clk);
    bus.i_rx_data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] opc, input logic [63:0] addr, input logic [63:0] data);
    send_byte(opc);
    for (int k = 0; k < 8; k++) send_byte(addr[8*k +: 8]);
    if (opc == 8'h02) for (int k = 0; k < 8; k++) send_byte(data[8*k +: 8]);
  endtask

  task automatic push_op(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] data, input bit cd);
    op_t o;
    o.op = op; o.addr = addr; o.data = data; o.chk_data = cd;
    exp_op.push_back(o);
  endtask

  task automatic push_bytes(input logic [63:0] v, input int n);
    for (int k = 0; k < n; k++) exp_tx.push_back(v[8*k +: 8]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_op.size() != 0 || busy !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now(name);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.i_rx_data       = 8'h00;
    bus.i_rx_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_op", 64'(bus.o_mem_op), 64'd0);
    check("rst_mem_addr", bus.o_mem_addr, 64'd0);
    check("rst_mem_data", bus.o_mem_data, 64'd0);
    check("rst_tx_data", 64'(bus.o_tx_data), 64'd0);
    check("rst_tx_valid", 64'(bus.o_tx_data_valid), 64'd0);
    check("rst_rx_rdy", 64'(bus.o_rx_data_rdy), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // WRITE 0x10 <- 0x1122334455667788
    push_op(2'd2, 64'h10, 64'h1122_3344_5566_7788, 1'b1);
    exp_tx.push_back(8'hAA);
    send_frame(8'h02, 64'h10, 64'h1122_3344_5566_7788);
    wait_done("write_done");

    // READ 0x10 through the pending handshake
    push_op(2'd1, 64'h10, 64'd0, 1'b0);
    push_bytes(64'h1122_3344_5566_7788, 8);
    send_frame(8'h01, 64'h10, 64'd0);
    wait_done("read_mem_done");

    // Register-space READ with no pending phase
    push_op(2'd1, 64'h8000_0000_0000_0001, 64'd0, 1'b0);
    push_bytes(64'h1, 8);
    send_frame(8'h01, 64'h8000_0000_0000_0001, 64'd0);
    wait_done("read_reg_done");

    // Bad opcode
    exp_tx.push_back(8'hEE);
    send_byte(8'h7F);
    wait_done("bad_opcode_done");
    check("err_after_bad_opcode", 64'(err), 64'd1);

    // Truncated frame then inter-byte timeout
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h00);
    check("busy_mid_frame", 64'(busy), 64'd1);
    repeat (TMO + 20) @(negedge clk);
    check("busy_after_timeout", 64'(busy), 64'd0);
    check("err_after_timeout", 64'(err), 64'd2);
    check("rx_rdy_after_timeout", 64'(bus.o_rx_data_rdy), 64'd1);

    push_op(2'd2, 64'h20, 64'hCAFE_F00D_DEAD_BEEF, 1'b1);
    exp_tx.push_back(8'hAA);
    send_frame(8'h02, 64'h20, 64'hCAFE_F00D_DEAD_BEEF);
    wait_done("write_after_timeout_done");

    // Reset in the middle of a READ response
    push_op(2'd1, 64'h10, 64'd0, 1'b0);
    exp_tx.push_back(8'h88);
    send_frame(8'h01, 64'h10, 64'd0);
    begin
      int n = 0;
      while (exp_tx.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (n >= 500) fail_now("first_resp_byte");
    end
    @(negedge clk);
    check("busy_in_tx", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_mem_op", 64'(bus.o_mem_op), 64'd0);
    check("mid_rst_mem_addr", bus.o_mem_addr, 64'd0);
    check("mid_rst_tx_valid", 64'(bus.o_tx_data_valid), 64'd0);
    check("mid_rst_tx_data", 64'(bus.o_tx_data), 64'd0);
    check("mid_rst_rx_rdy", 64'(bus.o_rx_data_rdy), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("busy_after_rst", 64'(busy), 64'd0);

    check("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
    check("op_queue_drained", 64'(exp_op.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
